// File: rtl/itlb_refill_ctrl.sv
// ITLB miss handler: captures a missing VPN/ASID, runs one page-table walk, then fills a victim.
// Define ITLB_REFILL_INVALID_FIRST_EN to prefer never-filled entries over the round-robin pointer.
module itlb_refill_ctrl #(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned VPN_WD  = 20,
   parameter int unsigned ASID_W  = 9
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                tlb_flush_i,
   input  logic                lookup_valid_i,
   input  logic [VPN_WD-1:0]   lookup_vpn_i,
   input  logic [ASID_W-1:0]   lookup_asid_i,
   input  logic [ENTRIES-1:0]  hit_vec_i,
   output logic                ptw_req_valid_o,
   input  logic                ptw_req_ready_i,
   output logic [VPN_WD-1:0]   ptw_req_vpn_o,
   output logic [ASID_W-1:0]   ptw_req_asid_o,
   input  logic                ptw_resp_valid_i,
   input  logic                ptw_resp_g_i,
   input  logic                ptw_resp_fault_i,
   output logic [ENTRIES-1:0]  fill_en_o,
   output logic [VPN_WD-1:0]   fill_vpn_o,
   output logic [ASID_W-1:0]   fill_asid_o,
   output logic                fill_g_o,
   output logic                busy_o,
   output logic                fault_o
);

   localparam int unsigned PTR_W = $clog2(ENTRIES);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StFill} state_e;

   state_e               state_q, state_d;
   logic [VPN_WD-1:0]    vpn_q, vpn_d;
   logic [ASID_W-1:0]    asid_q, asid_d;
   logic                 g_q, g_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [ENTRIES-1:0]   valid_q, valid_d;
   logic                 drop_q, drop_d;
   logic                 fault_q, fault_d;
   logic [PTR_W-1:0]     victim;

`ifdef ITLB_REFILL_INVALID_FIRST_EN
   // Descending scan so the lowest invalid index wins; falls back to the pointer when all valid.
   always_comb begin
      victim = ptr_q;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) victim = PTR_W'(i);
      end
   end
`else
   assign victim = ptr_q;
`endif

   always_comb begin
      state_d         = state_q;
      vpn_d           = vpn_q;
      asid_d          = asid_q;
      g_d             = g_q;
      ptr_d           = ptr_q;
      valid_d         = valid_q;
      drop_d          = drop_q;
      fault_d         = 1'b0;
      ptw_req_valid_o = 1'b0;
      fill_en_o       = '0;

      unique case (state_q)
         StIdle: begin
            if (lookup_valid_i && (hit_vec_i == '0) && !tlb_flush_i) begin
               state_d = StReq;
               vpn_d   = lookup_vpn_i;
               asid_d  = lookup_asid_i;
            end
         end
         StReq: begin
            // A flush withdraws the request in the same cycle so the walker never accepts it.
            if (tlb_flush_i) begin
               state_d = StIdle;
            end else begin
               ptw_req_valid_o = 1'b1;
               if (ptw_req_ready_i) state_d = StWait;
            end
         end
         StWait: begin
            if (tlb_flush_i) drop_d = 1'b1;
            if (ptw_resp_valid_i) begin
               drop_d = 1'b0;
               if (drop_q || tlb_flush_i) begin
                  state_d = StIdle;
               end else if (ptw_resp_fault_i) begin
                  fault_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  g_d     = ptw_resp_g_i;
                  state_d = StFill;
               end
            end
         end
         StFill: begin
            state_d = StIdle;
            if (!tlb_flush_i) begin
               fill_en_o       = ENTRIES'(1) << victim;
               valid_d[victim] = 1'b1;
               ptr_d           = victim + PTR_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (tlb_flush_i) valid_d = '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         vpn_q   <= '0;
         asid_q  <= '0;
         g_q     <= 1'b0;
         ptr_q   <= '0;
         valid_q <= '0;
         drop_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vpn_q   <= vpn_d;
         asid_q  <= asid_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
         fault_q <= fault_d;
      end
   end

   assign ptw_req_vpn_o  = vpn_q;
   assign ptw_req_asid_o = asid_q;
   assign fill_vpn_o     = vpn_q;
   assign fill_asid_o    = asid_q;
   assign fill_g_o       = g_q;
   assign busy_o         = (state_q != StIdle);
   assign fault_o        = fault_q;

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Randomized bench for itlb_refill_ctrl against a transaction-level model of victim selection.
module tb_itlb_refill_ctrl;

   localparam int unsigned ENTRIES = 8;
   localparam int unsigned VPN_WD  = 20;
   localparam int unsigned ASID_W  = 9;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                tlb_flush;
   logic                lookup_valid;
   logic [VPN_WD-1:0]   lookup_vpn;
   logic [ASID_W-1:0]   lookup_asid;
   logic [ENTRIES-1:0]  hit_vec;
   logic                ptw_req_valid;
   logic                ptw_req_ready;
   logic [VPN_WD-1:0]   ptw_req_vpn;
   logic [ASID_W-1:0]   ptw_req_asid;
   logic                ptw_resp_valid;
   logic                ptw_resp_g;
   logic                ptw_resp_fault;
   logic [ENTRIES-1:0]  fill_en;
   logic [VPN_WD-1:0]   fill_vpn;
   logic [ASID_W-1:0]   fill_asid;
   logic                fill_g;
   logic                busy;
   logic                fault;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: which entries hold a translation since the last flush, and the RR pointer.
   bit [ENTRIES-1:0] mdl_valid;
   int               mdl_ptr;

   itlb_refill_ctrl #(
      .ENTRIES (ENTRIES),
      .VPN_WD  (VPN_WD),
      .ASID_W  (ASID_W)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .tlb_flush_i      (tlb_flush),
      .lookup_valid_i   (lookup_valid),
      .lookup_vpn_i     (lookup_vpn),
      .lookup_asid_i    (lookup_asid),
      .hit_vec_i        (hit_vec),
      .ptw_req_valid_o  (ptw_req_valid),
      .ptw_req_ready_i  (ptw_req_ready),
      .ptw_req_vpn_o    (ptw_req_vpn),
      .ptw_req_asid_o   (ptw_req_asid),
      .ptw_resp_valid_i (ptw_resp_valid),
      .ptw_resp_g_i     (ptw_resp_g),
      .ptw_resp_fault_i (ptw_resp_fault),
      .fill_en_o        (fill_en),
      .fill_vpn_o       (fill_vpn),
      .fill_asid_o      (fill_asid),
      .fill_g_o         (fill_g),
      .busy_o           (busy),
      .fault_o          (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int mdl_victim();
`ifdef ITLB_REFILL_INVALID_FIRST_EN
      for (int i = 0; i < ENTRIES; i++) if (!mdl_valid[i]) return i;
`endif
      return mdl_ptr;
   endfunction

   task automatic clear_inputs();
      tlb_flush      = 1'b0;
      lookup_valid   = 1'b0;
      lookup_vpn     = VPN_WD'($urandom);
      lookup_asid    = ASID_W'($urandom);
      hit_vec        = '0;
      ptw_req_ready  = 1'b0;
      ptw_resp_valid = 1'b0;
      ptw_resp_g     = 1'($urandom);
      ptw_resp_fault = 1'($urandom);
   endtask

   // Inputs change at the falling edge; outputs are sampled 1ns later, well before the rising edge.
   task automatic idle_chk(input string tag);
      clear_inputs();
      #1;
      check({tag, "_busy"}, busy, 0);
      check({tag, "_reqv"}, ptw_req_valid, 0);
      check({tag, "_fill"}, fill_en, 0);
      check({tag, "_fault"}, fault, 0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mdl_valid = '0;
      mdl_ptr   = 0;
   endtask

   // flush_at: 0 none, 1 with the miss (idle), 2 in REQ, 3 in WAIT, 4 in FILL.
   task automatic txn(input logic [VPN_WD-1:0] vpn, input logic [ASID_W-1:0] asid,
                      input int rdy_wait, input int resp_wait, input bit g, input bit flt,
                      input int flush_at);
      int v;
      clear_inputs();
      lookup_valid = 1'b1;
      lookup_vpn   = vpn;
      lookup_asid  = asid;
      tlb_flush    = (flush_at == 1);
      #1;
      check("cap_busy", busy, 0);
      check("cap_fault", fault, 0);
      @(negedge clk);
      if (flush_at == 1) begin
         mdl_valid = '0;
         idle_chk("flush_idle");
         return;
      end
      for (int k = 0; k <= rdy_wait; k++) begin
         clear_inputs();
         lookup_valid  = 1'b1;
         ptw_req_ready = (k == rdy_wait);
         tlb_flush     = (flush_at == 2);
         #1;
         if (flush_at == 2) begin
            @(negedge clk);
            mdl_valid = '0;
            idle_chk("flush_req");
            return;
         end
         check("req_valid", ptw_req_valid, 1);
         check("req_vpn", ptw_req_vpn, vpn);
         check("req_asid", ptw_req_asid, asid);
         check("req_busy", busy, 1);
         @(negedge clk);
      end
      if (flush_at == 3) begin
         for (int k = 0; k < 4; k++) begin
            clear_inputs();
            tlb_flush      = (k == 0);
            ptw_resp_valid = (k == 3);
            #1;
            check("drop_busy", busy, 1);
            @(negedge clk);
         end
         mdl_valid = '0;
         idle_chk("flush_wait");
         return;
      end
      for (int k = 0; k <= resp_wait; k++) begin
         clear_inputs();
         lookup_valid   = 1'b1;
         ptw_resp_valid = (k == resp_wait);
         ptw_resp_g     = g;
         ptw_resp_fault = flt;
         #1;
         check("wait_reqv", ptw_req_valid, 0);
         check("wait_fill", fill_en, 0);
         check("wait_busy", busy, 1);
         @(negedge clk);
      end
      clear_inputs();
      tlb_flush = (flush_at == 4) && !flt;
      #1;
      if (flt) begin
         check("fault_pulse", fault, 1);
         check("fault_fill", fill_en, 0);
         check("fault_busy", busy, 0);
      end else if (flush_at == 4) begin
         check("flush_fill", fill_en, 0);
         mdl_valid = '0;
      end else begin
         v = mdl_victim();
         check("fill_en", fill_en, 32'(1) << v);
         check("fill_vpn", fill_vpn, vpn);
         check("fill_asid", fill_asid, asid);
         check("fill_g", fill_g, g);
         check("fill_fault", fault, 0);
         mdl_valid[v] = 1'b1;
         mdl_ptr      = (v + 1) % ENTRIES;
      end
      @(negedge clk);
      if (flt) begin
         clear_inputs();
         #1;
         check("fault_once", fault, 0);
         @(negedge clk);
      end
      if (flush_at == 4 && !flt) idle_chk("flush_fill_after");
   endtask

   initial begin
      clear_inputs();
      do_reset();
      #1;
      check("rst_reqv", ptw_req_valid, 0);
      check("rst_fill", fill_en, 0);
      check("rst_fault", fault, 0);
      check("rst_busy", busy, 0);
      check("rst_vpn", ptw_req_vpn, 0);
      check("rst_asid", ptw_req_asid, 0);
      check("rst_fvpn", fill_vpn, 0);
      check("rst_fasid", fill_asid, 0);
      check("rst_fg", fill_g, 0);
      @(negedge clk);

      txn(20'h004FF, 9'd2, 0, 0, 1'b0, 1'b0, 0);

      // Nine back-to-back fills from reset: sequential entries, then wrap to entry 0.
      do_reset();
      for (int i = 0; i < 9; i++) txn(20'h00100 + 20'(i), 9'd5, 0, 0, 1'(i), 1'b0, 0);

      // Three fills, flush, miss: invalid-first picks entry 0, plain round-robin picks entry 3.
      do_reset();
      for (int i = 0; i < 3; i++) txn(20'h00200 + 20'(i), 9'd1, 0, 0, 1'b0, 1'b0, 0);
      txn(20'h00300, 9'd1, 0, 0, 1'b0, 1'b0, 1);
      txn(20'h00301, 9'd1, 0, 0, 1'b1, 1'b0, 0);

      do_reset();
      for (int i = 0; i < 3; i++) txn(20'h00200 + 20'(i), 9'd1, 0, 0, 1'b0, 1'b0, 0);
      txn(20'h00302, 9'd1, 0, 0, 1'b0, 1'b0, 0);

      // Faulted walk leaves the pointer alone; the next fill shows it.
      txn(20'h00400, 9'd3, 1, 2, 1'b0, 1'b1, 0);
      txn(20'h00401, 9'd3, 0, 0, 1'b0, 1'b0, 0);

      txn(20'h00500, 9'd4, 0, 0, 1'b0, 1'b0, 3);
      txn(20'h00501, 9'd4, 2, 0, 1'b0, 1'b0, 2);
      txn(20'h00502, 9'd4, 0, 1, 1'b1, 1'b0, 4);
      txn(20'h00503, 9'd4, 0, 0, 1'b1, 1'b0, 0);

      // Single and multiple hits both leave the controller idle.
      for (int i = 0; i < 4; i++) begin
         clear_inputs();
         lookup_valid = 1'b1;
         hit_vec      = ENTRIES'($urandom_range(1, (1 << ENTRIES) - 1));
         @(negedge clk);
         idle_chk("hit");
      end

      // Asynchronous reset while a request is outstanding.
      clear_inputs();
      lookup_valid = 1'b1;
      @(negedge clk);
      clear_inputs();
      #1;
      check("pre_rst_reqv", ptw_req_valid, 1);
      rst = 1'b1;
      #1;
      check("async_rst_reqv", ptw_req_valid, 0);
      check("async_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      mdl_valid = '0;
      mdl_ptr   = 0;
      txn(20'h00600, 9'd7, 0, 0, 1'b0, 1'b0, 0);

      for (int i = 0; i < 80; i++) begin
         int f;
         f = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
         txn(VPN_WD'($urandom), ASID_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), ($urandom_range(0, 4) == 0), f);
         if ($urandom_range(0, 3) == 0) begin
            clear_inputs();
            lookup_valid = 1'b1;
            hit_vec      = ENTRIES'($urandom_range(1, (1 << ENTRIES) - 1));
            @(negedge clk);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/itlb_refill_ctrl.md
# itlb_refill_ctrl

Miss-handling and refill controller for the instruction TLB. It watches the per-entry hit vector produced by the ITLB tag entries. On a miss it captures the VPN/ASID, issues one page-table-walk request, and waits for the response. It then selects a victim entry and drives a one-cycle, one-hot write enable with the fill data into the tag entries.

## Interface
Parameters:
- ENTRIES, 8, number of ITLB tag entries (power of two, ≥2)
- VPN_WD, `VPN0_WD + `VPN1_WD (20), tag VPN width
- ASID_W, `ASID_WD (9), ASID width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- tlb_flush_i  in  1  flush all ITLB entries
- lookup_valid_i  in  1  fetch translation request this cycle
- lookup_vpn_i  in  VPN_WD  requested VPN
- lookup_asid_i  in  ASID_W  current ASID
- hit_vec_i  in  ENTRIES  per-entry hit from tag entries, same cycle as lookup
- ptw_req_valid_o  out  1  walk request valid
- ptw_req_ready_i  in  1  walker accepts request
- ptw_req_vpn_o  out  VPN_WD  captured miss VPN
- ptw_req_asid_o  out  ASID_W  captured miss ASID
- ptw_resp_valid_i  in  1  walk response, single-cycle pulse
- ptw_resp_g_i  in  1  PTE global bit
- ptw_resp_fault_i  in  1  walk faulted, no fill
- fill_en_o  out  ENTRIES  one-hot write enable to tag entries
- fill_vpn_o  out  VPN_WD  fill tag VPN
- fill_asid_o  out  ASID_W  fill ASID
- fill_g_o  out  1  fill global bit
- busy_o  out  1  state ≠ IDLE
- fault_o  out  1  one-cycle pulse on faulted walk

## Operation
- FSM states: IDLE, REQ, WAIT, FILL.
- IDLE → REQ: when lookup_valid_i=1 and hit_vec_i=0 with no flush. Capture lookup_vpn_i and lookup_asid_i.
- REQ: ptw_req_valid_o=1, and VPN/ASID are held stable. On ptw_req_ready_i=1 → WAIT.
- WAIT: on ptw_resp_valid_i:
  - If the response is not dropped and ptw_resp_fault_i=1, pulse fault_o and go to IDLE.
  - If the response is dropped, go to IDLE with no fill and no fault.
  - Otherwise latch ptw_resp_g_i and go to FILL.
- FILL: fill_en_o = onehot(victim) for exactly one cycle, with fill_vpn_o, fill_asid_o and fill_g_o valid. Set the valid mirror bit for the victim, advance the round-robin pointer to (victim+1) mod ENTRIES, then go to IDLE.
- Misses arriving while busy_o=1 are ignored. The front end must hold or replay them.
- Multiple hit_vec_i bits set counts as a hit, and no action is taken.
- Internal valid mirror (ENTRIES bits) tracks which entries have been filled since the last flush.
- Flush handling:
  - Always clears the valid mirror. The round-robin pointer is unchanged.
  - In IDLE, suppresses miss capture.
  - In REQ, aborts to IDLE; the request is withdrawn.
  - In WAIT, sets a drop flag; the eventual response is consumed and discarded.
  - In FILL, forces fill_en_o=0 that cycle and goes to IDLE.
- Reset mid-operation returns to IDLE immediately and clears all state.

## Timing
- Reset values:
  - FSM = IDLE; pointer, valid mirror and drop flag = 0.
  - All outputs 0: ptw_req_valid_o, fill_en_o, fault_o, busy_o, and the data outputs.
- Miss seen in cycle N → ptw_req_valid_o=1 from cycle N+1.
- Request accepted at the handshake edge: in the cycle where valid=1 and ready=1, ptw_req_valid_o falls the next cycle.
- Response in cycle M → fill_en_o in cycle M+1 → IDLE in M+2. A new miss can be captured in M+2.
- Fault response in cycle M → fault_o high in cycle M+1 only, and IDLE in M+1.
- Minimum miss-to-fill latency with a zero-wait walker is 3 cycles (N+1 req/ready, response at N+2, fill at N+3).
- Pointer wrap: ENTRIES-1 → 0.

## Configuration
- ITLB_REFILL_INVALID_FIRST_EN defined: victim = lowest-index entry whose valid-mirror bit is 0. If all entries are valid, victim = round-robin pointer.
- Not defined: victim is always the round-robin pointer, and the valid mirror affects nothing.

## Test plan
- Reset, then lookup_vpn_i=0x4FF, asid=2, hit_vec_i=0 → ptw_req_valid_o=1 next cycle with vpn 0x4FF, asid 2. With ready=1 and a response at g=0 two cycles later → fill_en_o=0x01 for one cycle.
- Four back-to-back misses (VPNs 0x100–0x103), no flush, macro off → fill_en_o sequence 0x01, 0x02, 0x04, 0x08. After eight fills the ninth fill hits 0x01 (wrap).
- Fault response (ptw_resp_fault_i=1) → fault_o is a one-cycle pulse, fill_en_o stays 0, and the pointer is unchanged.
- tlb_flush_i asserted in WAIT, response arrives 3 cycles later → no fill_en_o, no fault_o, busy_o=0 the cycle after the response.
- Macro on:
  - Fill entries 0–2, then flush, then miss → fill_en_o=0x01 (invalid-first), not 0x08.
  - Run the same sequence with no flush → 0x08.
- rst_i asserted in REQ → ptw_req_valid_o and busy_o are 0 asynchronously. A following miss restarts at fill_en_o=0x01.
